instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Downstream neighbour of the PC register: takes the registered PC and fetches one instruction per PC from the instruction memory over a valid/ready request plus valid response bus.
- Presents the instruction to decode with a valid/ready handshake.
- Drives o_pc_stall so the PC-next mux holds the PC until the current instruction is consumed.
- Supports variable memory latency, redirects (flush) and memory errors.

Parameters:
- XLEN, 32, address/data width.
- NOP_INSTR, 32'h0000_0013, instruction substituted on fault or flush (addi x0,x0,0).

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-low reset
- i_pc  in  XLEN  current PC, word-aligned
- i_flush  in  1  redirect: abandon current fetch
- o_imem_req_valid  out  1  request valid
- o_imem_req_addr  out  XLEN  request address
- i_imem_req_ready  in  1  memory accepts request
- i_imem_rsp_valid  in  1  response valid, one per accepted request
- i_imem_rsp_data  in  XLEN  instruction word
- i_imem_rsp_err  in  1  bus error qualifier for the response
- o_instr  out  XLEN  fetched instruction
- o_instr_pc  out  XLEN  PC of o_instr
- o_instr_valid  out  1  instruction valid
- i_instr_ready  in  1  decode accepts
- o_fetch_fault  out  1  o_instr came from an errored response
- o_pc_stall  out  1  hold PC

Behaviour:
- Reset is synchronous: it is sampled only on the i_clk rising edge while i_reset=0.
- Reset values:
  - state=IDLE
  - o_imem_req_valid=0
  - o_imem_req_addr=0
  - o_instr=NOP_INSTR
  - o_instr_pc=0
  - o_instr_valid=0
  - o_fetch_fault=0
- Reset mid-operation abandons any outstanding request. The memory is reset by the same i_reset, so no stale response is expected.
- o_pc_stall is combinational: o_pc_stall = !(o_instr_valid && i_instr_ready && !i_flush).
- An accept is valid && ready && !i_flush.
- FSM states:
  - IDLE: one cycle after reset. Latch addr=i_pc, go to REQ.
  - REQ: o_imem_req_valid=1, addr stable.
    - Flush: relatch addr=i_pc, stay in REQ.
    - Else if i_imem_req_ready: go to WAIT.
  - WAIT: waiting for the response.
    - rsp_valid && !flush: capture o_instr=data (NOP_INSTR if err), o_instr_pc=addr, o_fetch_fault=err, o_instr_valid=1, go to HOLD.
    - rsp_valid && flush: discard the response, latch addr=i_pc, go to REQ.
    - flush with no rsp: go to DROP.
  - DROP: swallow the next response, then latch addr=i_pc and go to REQ. A further flush while in DROP has no additional effect.
  - HOLD: o_instr_valid=1, outputs stable.
    - Accept: clear valid, latch addr=i_pc (the PC has advanced this edge, so latch the post-edge value on the next cycle). Go to IDLE-equivalent single latch cycle, then REQ.
    - Flush: clear valid and fault, same path as accept.
- Flush has priority over accept and over capture.
- Latency with a zero-wait memory (ready=1, rsp one cycle after handshake): latch, REQ, WAIT, HOLD. One instruction per 4 cycles minimum, which is acceptable for single-cycle core timing.
- Output stability: o_imem_req_addr must not change while req_valid=1 without a handshake, except on flush.
- The memory must not return a response without a request. A response arriving in IDLE, REQ or HOLD is ignored.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds two outputs, each 32 bits and saturating at all-ones, both reset to 0:
  - o_perf_fetch_cnt: count of accepts.
  - o_perf_stall_cnt: cycles with state in REQ, WAIT or DROP.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - the state enum fetch_state_e {IDLE, REQ, WAIT, DROP, HOLD}
  - the NOP_INSTR localparam default
  - the XLEN default
- Optional sub-module fetch_perf_ctr: one parameterised saturating counter, instantiated twice under FETCH_PERF_EN.

Test Plan:
- Reset release with i_pc=0, ready=1, memory returns 32'h00500093 one cycle after handshake -> req addr 0, then o_instr=32'h00500093, o_instr_pc=0, valid=1; o_pc_stall=1 until ready=1.
- Memory latency 5 cycles, i_pc=32'h40 -> req_valid held with addr 32'h40 while ready=0; valid rises the cycle after rsp_valid; exactly one request is issued.
- rsp_err=1 at pc 32'h80 -> o_instr=32'h00000013, o_fetch_fault=1, valid=1; both clear after accept.
- Flush in WAIT, i_pc changes to 32'h100 -> late response discarded (DROP), next request addr=32'h100, and only the 32'h100 instruction is presented.
- Flush in the same cycle as rsp_valid, and flush together with i_instr_ready in HOLD -> no accept, o_pc_stall=1, refetch from new i_pc.
- With FETCH_PERF_EN: 10 fetches at 5-cycle latency -> o_perf_fetch_cnt=10, o_perf_stall_cnt matches the counted REQ/WAIT cycles; i_reset=0 mid-run clears both to 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT      = 32;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [2:0] {
    IDLE,  // single cycle that latches the PC
    REQ,   // request presented to instruction memory
    WAIT,  // request accepted, waiting for the response
    DROP,  // flushed while waiting, swallow the stale response
    HOLD   // instruction presented to decode
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Saturating event counter with synchronous active-low reset.
module fetch_perf_ctr #(
  parameter int unsigned Width = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc,
  output logic [Width-1:0] o_count
);

  logic [Width-1:0] count_q;

  // Count events, sticking at all-ones.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      count_q <= '0;
    end else if (i_inc && (count_q != '1)) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one memory request per PC, result handed to decode
// with valid/ready, PC held via o_pc_stall until the instruction is consumed.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEFAULT)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_imem_req_valid,
  output logic [XLEN-1:0] o_imem_req_addr,
  input  logic            i_imem_req_ready,
  input  logic            i_imem_rsp_valid,
  input  logic [XLEN-1:0] i_imem_rsp_data,
  input  logic            i_imem_rsp_err,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  output logic            o_instr_valid,
  input  logic            i_instr_ready,
  output logic            o_fetch_fault,
`ifdef FETCH_PERF_EN
  output logic [31:0]     o_perf_fetch_cnt,
  output logic [31:0]     o_perf_stall_cnt,
`endif
  output logic            o_pc_stall
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;
  logic            accept;

  // Flush outranks the decode handshake.
  assign accept = valid_q && i_instr_ready && !i_flush;

  // Next-state and datapath updates for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    unique case (state_q)
      IDLE: begin
        addr_d  = i_pc;
        state_d = REQ;
      end
      REQ: begin
        if (i_flush) begin
          addr_d = i_pc;
        end else if (i_imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_imem_rsp_valid) begin
          if (i_flush) begin
            addr_d  = i_pc;
            state_d = REQ;
          end else begin
            instr_d    = i_imem_rsp_err ? NOP_INSTR : i_imem_rsp_data;
            instr_pc_d = addr_q;
            fault_d    = i_imem_rsp_err;
            valid_d    = 1'b1;
            state_d    = HOLD;
          end
        end else if (i_flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        // Further flushes change nothing; the PC is sampled when the stale
        // response has gone by.
        if (i_imem_rsp_valid) begin
          addr_d  = i_pc;
          state_d = REQ;
        end
      end
      HOLD: begin
        if (i_flush) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          fault_d = 1'b0;
          state_d = IDLE;
        end else if (accept) begin
          // PC advances on this edge; IDLE picks up the new value next cycle.
          valid_d = 1'b0;
          fault_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  assign o_imem_req_valid = (state_q == REQ);
  assign o_imem_req_addr  = addr_q;
  assign o_instr          = instr_q;
  assign o_instr_pc       = instr_pc_q;
  assign o_instr_valid    = valid_q;
  assign o_fetch_fault    = fault_q;
  assign o_pc_stall       = !accept;

`ifdef FETCH_PERF_EN
  logic stall_cycle;

  assign stall_cycle = (state_q == REQ) || (state_q == WAIT) || (state_q == DROP);

  fetch_perf_ctr #(
    .Width (32)
  ) u_fetch_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (accept),
    .o_count (o_perf_fetch_cnt)
  );

  fetch_perf_ctr #(
    .Width (32)
  ) u_stall_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (stall_cycle),
    .o_count (o_perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small latency-programmable memory.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        flush;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        mem_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_fault;
  logic        pc_stall;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit u_dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .i_pc             (pc),
    .i_flush          (flush),
    .o_imem_req_valid (req_valid),
    .o_imem_req_addr  (req_addr),
    .i_imem_req_ready (mem_ready),
    .i_imem_rsp_valid (rsp_valid),
    .i_imem_rsp_data  (rsp_data),
    .i_imem_rsp_err   (rsp_err),
    .o_instr          (instr),
    .o_instr_pc       (instr_pc),
    .o_instr_valid    (instr_valid),
    .i_instr_ready    (instr_ready),
    .o_fetch_fault    (fetch_fault),
`ifdef FETCH_PERF_EN
    .o_perf_fetch_cnt (perf_fetch),
    .o_perf_stall_cnt (perf_stall),
`endif
    .o_pc_stall       (pc_stall)
  );

  // Memory model: response mem_lat cycles after the request handshake.
  int          mem_lat = 1;
  logic        mem_err = 1'b0;
  logic        pend = 1'b0;
  logic        pend_err = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = '0;
  int          hs_count = 0;
  logic [31:0] hs_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a | 32'h0000_0013);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      pend <= 1'b0;
      cnt  <= 0;
    end else if (req_valid && mem_ready) begin
      pend      <= 1'b1;
      cnt       <= mem_lat - 1;
      pend_addr <= req_addr;
      pend_err  <= mem_err;
      hs_count  <= hs_count + 1;
      hs_addr   <= req_addr;
    end else if (pend) begin
      if (cnt == 0) pend <= 1'b0;
      else cnt <= cnt - 1;
    end
  end

  assign rsp_valid = pend && (cnt == 0);
  assign rsp_data  = rsp_valid ? mem_word(pend_addr) : 32'h0;
  assign rsp_err   = rsp_valid && pend_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bounded wait for o_instr_valid; reports rsp_valid of the preceding cycle.
  task automatic wait_valid(input string tag, output logic rsp_before);
    logic prev;
    rsp_before = 1'b0;
    for (int i = 0; i < 40; i++) begin
      prev = rsp_valid;
      tick();
      if (instr_valid) begin
        rsp_before = prev;
        break;
      end
    end
    check(tag, {31'b0, instr_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic rb;
    int   hs0;

    rst_n       = 1'b0;
    pc          = 32'h0;
    flush       = 1'b0;
    mem_ready   = 1'b1;
    instr_ready = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_req_valid", {31'b0, req_valid}, 32'd0);
    check("rst_req_addr", req_addr, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_fault", {31'b0, fetch_fault}, 32'd0);
    check("rst_stall", {31'b0, pc_stall}, 32'd1);

    // Zero-wait fetch at PC 0
    rst_n = 1'b1;
    tick();
    check("t1_req_valid", {31'b0, req_valid}, 32'd1);
    check("t1_req_addr", req_addr, 32'h0);
    tick();
    wait_valid("t1_valid", rb);
    check("t1_instr", instr, 32'h0050_0093);
    check("t1_instr_pc", instr_pc, 32'h0);
    check("t1_stall_hold", {31'b0, pc_stall}, 32'd1);
    instr_ready = 1'b1;
    pc          = 32'h40;
    mem_ready   = 1'b0;
    mem_lat     = 5;
    #1;
    check("t1_stall_ready", {31'b0, pc_stall}, 32'd0);
    tick();
    instr_ready = 1'b0;
    check("t1_valid_clr", {31'b0, instr_valid}, 32'd0);

    // Slow memory at PC 0x40: request held while not ready
    tick();
    hs0 = hs_count;
    for (int i = 0; i < 3; i++) begin
      check("t2_req_held", {31'b0, req_valid}, 32'd1);
      check("t2_addr_held", req_addr, 32'h40);
      tick();
    end
    mem_ready = 1'b1;
    tick();
    wait_valid("t2_valid", rb);
    check("t2_valid_after_rsp", {31'b0, rb}, 32'd1);
    check("t2_instr", instr, 32'h0000_0053);
    check("t2_instr_pc", instr_pc, 32'h40);
    check("t2_one_req", hs_count - hs0, 32'd1);

    // Bus error at PC 0x80
    instr_ready = 1'b1;
    pc          = 32'h80;
    mem_lat     = 1;
    mem_err     = 1'b1;
    tick();
    instr_ready = 1'b0;
    wait_valid("t3_valid", rb);
    check("t3_instr", instr, 32'h0000_0013);
    check("t3_fault", {31'b0, fetch_fault}, 32'd1);
    check("t3_instr_pc", instr_pc, 32'h80);
    instr_ready = 1'b1;
    mem_err     = 1'b0;
    pc          = 32'hC0;
    mem_lat     = 5;
    tick();
    instr_ready = 1'b0;
    check("t3_valid_clr", {31'b0, instr_valid}, 32'd0);
    check("t3_fault_clr", {31'b0, fetch_fault}, 32'd0);

    // Flush while waiting on PC 0xC0, redirect to 0x100
    hs0 = hs_count;
    tick();
    tick();
    check("t4_in_wait", {31'b0, req_valid}, 32'd0);
    flush = 1'b1;
    pc    = 32'h100;
    tick();
    flush   = 1'b0;
    mem_lat = 1;
    check("t4_drop_no_req", {31'b0, req_valid}, 32'd0);
    wait_valid("t4_valid", rb);
    check("t4_instr_pc", instr_pc, 32'h100);
    check("t4_instr", instr, 32'h0000_0113);
    check("t4_req_addr", hs_addr, 32'h100);
    check("t4_req_count", hs_count - hs0, 32'd2);

    // Flush coincident with the response
    instr_ready = 1'b1;
    pc          = 32'h140;
    tick();
    instr_ready = 1'b0;
    tick();
    tick();
    check("t5_rsp_now", {31'b0, rsp_valid}, 32'd1);
    flush = 1'b1;
    pc    = 32'h180;
    tick();
    flush = 1'b0;
    check("t5_no_capture", {31'b0, instr_valid}, 32'd0);
    check("t5_req_valid", {31'b0, req_valid}, 32'd1);
    check("t5_req_addr", req_addr, 32'h180);
    wait_valid("t5_valid", rb);
    check("t5_instr_pc", instr_pc, 32'h180);
    check("t5_instr", instr, 32'h0000_0193);

    // Flush together with decode ready in HOLD
    flush       = 1'b1;
    instr_ready = 1'b1;
    pc          = 32'h1C0;
    #1;
    check("t6_stall", {31'b0, pc_stall}, 32'd1);
    tick();
    flush       = 1'b0;
    instr_ready = 1'b0;
    check("t6_valid_clr", {31'b0, instr_valid}, 32'd0);
    wait_valid("t6_valid", rb);
    check("t6_instr_pc", instr_pc, 32'h1C0);
    check("t6_instr", instr, 32'h0000_01D3);

`ifdef FETCH_PERF_EN
    // Ten back-to-back fetches at 5-cycle latency: 8 cycles each, 6 stalled
    rst_n       = 1'b0;
    tick();
    check("p_rst_fetch", perf_fetch, 32'd0);
    check("p_rst_stall", perf_stall, 32'd0);
    rst_n       = 1'b1;
    pc          = 32'h200;
    mem_ready   = 1'b1;
    mem_lat     = 5;
    instr_ready = 1'b1;
    for (int i = 0; i < 80; i++) tick();
    check("p_fetch_cnt", perf_fetch, 32'd10);
    check("p_stall_cnt", perf_stall, 32'd60);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("p_clr_fetch", perf_fetch, 32'd0);
    check("p_clr_stall", perf_stall, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
